// File: rtl/serial_accum.sv
// Bit-serial unsigned accumulator: one full-adder slice plus a carry flop adds
// each accepted operand into the running total over WIDTH clocks, LSB first.
module serial_accum #(
  parameter int WIDTH  = 8,
  parameter bit SAT_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] din,
  input  logic             sat_mode,
  output logic [WIDTH-1:0] acc,
  output logic             acc_valid,
  output logic             ovf,
  output logic             busy
);

  // state  | meaning
  // IDLE   | waiting for an operand; in_ready high unless clr
  // SHIFT  | one sum bit per clock into the shadow copy, LSB first
  // COMMIT | carry holds the final carry-out; write acc and ovf

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    COMMIT = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] opnd;
  logic [WIDTH-1:0] sh;
  logic [CW-1:0]    cnt;
  logic             carry;
  logic             sat;
  logic             bit_a;
  logic             bit_b;

  assign in_ready = (state == IDLE) && !clr;
  assign busy     = (state != IDLE);
  assign bit_a    = opnd[cnt];
  assign bit_b    = sh[cnt];

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      acc       <= '0;
      ovf       <= 1'b0;
      acc_valid <= 1'b0;
      opnd      <= '0;
      sh        <= '0;
      cnt       <= '0;
      carry     <= 1'b0;
      sat       <= 1'b0;
    end else if (clr) begin
      // An aborted op never commits; acc and ovf restart from zero.
      state     <= IDLE;
      acc       <= '0;
      ovf       <= 1'b0;
      acc_valid <= 1'b0;
      cnt       <= '0;
      carry     <= 1'b0;
    end else begin
      acc_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid) begin
            opnd  <= din;
            sh    <= acc;
            sat   <= SAT_EN && sat_mode;
            carry <= 1'b0;
            cnt   <= '0;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          sh[cnt] <= bit_a ^ bit_b ^ carry;
          carry   <= (bit_a & bit_b) | (bit_a & carry) | (bit_b & carry);
          cnt     <= cnt + 1'b1;
          if (cnt == LAST) begin
            state <= COMMIT;
          end
        end
        COMMIT: begin
          acc       <= (carry && sat) ? '1 : sh;
          ovf       <= ovf | carry;
          acc_valid <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_accum.sv
// Self-checking bench for serial_accum (WIDTH=8, SAT_EN=1) against an
// integer-arithmetic model of the running total, overflow flag and timing.
module tb_serial_accum;

  localparam int W   = 8;
  localparam int MAX = (1 << W) - 1;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         clr = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] din = '0;
  logic         sat_mode = 1'b0;
  logic [W-1:0] acc;
  logic         acc_valid;
  logic         ovf;
  logic         busy;

  int checks = 0;
  int errors = 0;
  int m_acc  = 0;
  int m_ovf  = 0;

  serial_accum #(.WIDTH(W), .SAT_EN(1'b1)) dut (
    .clk       (clk),
    .rst       (rst),
    .clr       (clr),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .din       (din),
    .sat_mode  (sat_mode),
    .acc       (acc),
    .acc_valid (acc_valid),
    .ovf       (ovf),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int model_add(input int d, input bit s);
    int sum;
    sum = m_acc + d;
    if (sum > MAX) begin
      m_ovf = 1;
      m_acc = s ? MAX : (sum % (MAX + 1));
    end else begin
      m_acc = sum;
    end
    return m_acc;
  endfunction

  // Called at a negedge; returns at the negedge after the post-commit cycle.
  task automatic do_op(input logic [W-1:0] d, input bit s);
    int k;
    bit got;
    logic [W-1:0] old_acc;
    k = 0;
    while (!in_ready && k < 40) begin
      @(negedge clk);
      k++;
    end
    check("ready_wait", {31'd0, in_ready}, 32'd1);
    old_acc  = acc;
    in_valid = 1'b1;
    din      = d;
    sat_mode = s;
    @(negedge clk);
    in_valid = 1'b0;
    din      = W'($urandom);
    sat_mode = 1'($urandom);
    check("busy_after_accept", {31'd0, busy}, 32'd1);
    got = 1'b0;
    for (int n = 1; n <= 20 && !got; n++) begin
      @(negedge clk);
      if (acc_valid) begin
        got = 1'b1;
        check("latency", n, W + 1);
      end else begin
        check("acc_hold", {24'd0, acc}, {24'd0, old_acc});
      end
    end
    check("valid_seen", {31'd0, got}, 32'd1);
    void'(model_add(int'(d), s));
    check("acc", {24'd0, acc}, m_acc);
    check("ovf", {31'd0, ovf}, m_ovf);
    check("ready_after_commit", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    check("valid_single", {31'd0, acc_valid}, 32'd0);
  endtask

  task automatic clear_all();
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    m_acc = 0;
    m_ovf = 0;
    check("clr_acc", {24'd0, acc}, 32'd0);
  endtask

  // Abort in the 3rd SHIFT cycle, by clr (use_rst=0) or rst (use_rst=1).
  task automatic abort_test(input bit use_rst);
    clear_all();
    do_op(8'hF0, 1'b0);
    do_op(8'h50, 1'b0);
    check("pre_abort_ovf", {31'd0, ovf}, 32'd1);
    in_valid = 1'b1;
    din      = 8'h11;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    if (use_rst) rst = 1'b1; else clr = 1'b1;
    @(negedge clk);
    check("abort_acc", {24'd0, acc}, 32'd0);
    check("abort_ovf", {31'd0, ovf}, 32'd0);
    check("abort_valid", {31'd0, acc_valid}, 32'd0);
    check("abort_busy", {31'd0, busy}, 32'd0);
    rst = 1'b0;
    clr = 1'b0;
    #1;
    check("abort_ready", {31'd0, in_ready}, 32'd1);
    m_acc = 0;
    m_ovf = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      check("abort_no_commit", {31'd0, acc_valid}, 32'd0);
    end
  endtask

  int exp_q[$];
  int last_acc_cycle;
  int n_acc;

  initial begin
    // 1: reset
    @(negedge clk);
    @(negedge clk);
    check("rst_acc", {24'd0, acc}, 32'd0);
    check("rst_ovf", {31'd0, ovf}, 32'd0);
    check("rst_valid", {31'd0, acc_valid}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    rst = 1'b0;
    #1;
    check("rst_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);

    // 2: simple adds
    do_op(8'h05, 1'b0);
    do_op(8'h03, 1'b0);
    check("add_08", {24'd0, acc}, 32'h08);

    // 3: wrap mode overflow
    clear_all();
    do_op(8'hF0, 1'b0);
    do_op(8'h20, 1'b0);
    check("wrap_10", {24'd0, acc}, 32'h10);
    do_op(8'h01, 1'b0);
    check("wrap_11", {24'd0, acc}, 32'h11);
    check("wrap_ovf_sticky", {31'd0, ovf}, 32'd1);

    // 4: saturate mode
    clear_all();
    do_op(8'hF0, 1'b0);
    do_op(8'h20, 1'b1);
    check("sat_ff", {24'd0, acc}, 32'hFF);
    do_op(8'h01, 1'b1);
    do_op(8'h00, 1'b1);
    check("sat_hold_ff", {24'd0, acc}, 32'hFF);

    // 5: abort by clr, then by rst
    abort_test(1'b0);
    abort_test(1'b1);

    // random directed ops
    clear_all();
    for (int i = 0; i < 8; i++) begin
      do_op(W'($urandom), 1'($urandom));
    end

    // 6: in_valid held high, din changing every cycle
    clear_all();
    last_acc_cycle = -1;
    n_acc = 0;
    in_valid = 1'b1;
    for (int c = 0; c < 60; c++) begin
      if (acc_valid) begin
        check("stream_pending", exp_q.size(), 32'd1);
        if (exp_q.size() > 0) check("stream_acc", {24'd0, acc}, exp_q.pop_front());
      end
      din      = W'($urandom);
      sat_mode = 1'($urandom);
      #1;
      if (in_ready) begin
        if (last_acc_cycle >= 0) check("stream_spacing", c - last_acc_cycle, W + 2);
        last_acc_cycle = c;
        n_acc++;
        exp_q.push_back(model_add(int'(din), sat_mode));
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    for (int i = 0; i < 12 && exp_q.size() > 0; i++) begin
      if (acc_valid) check("stream_acc_tail", {24'd0, acc}, exp_q.pop_front());
      @(negedge clk);
    end
    check("stream_drained", exp_q.size(), 32'd0);
    check("stream_accepts", {31'd0, n_acc >= 5}, 32'd1);

    // clr together with in_valid while idle: no accept
    while (busy) @(negedge clk);
    in_valid = 1'b1;
    din      = 8'h3C;
    clr      = 1'b1;
    #1;
    check("clr_blocks_ready", {31'd0, in_ready}, 32'd0);
    @(negedge clk);
    in_valid = 1'b0;
    clr      = 1'b0;
    m_acc    = 0;
    m_ovf    = 0;
    check("clr_no_accept", {31'd0, busy}, 32'd0);
    check("clr_acc_zero", {24'd0, acc}, 32'd0);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      check("clr_no_commit", {31'd0, acc_valid}, 32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
